// File: rtl/uart_tx_sched.sv
// uart_tx_sched
//   Round-robin scheduler that drains four byte FIFOs into one UART byte
//   transmitter. Each grant produces one frame:
//     CMD, ~CMD, {6'b0,id}, PAYLOAD_LEN payload bytes, ~CMD, CMD
//
// Ports
//   SYS_CLK     in   1   clock, rising edge
//   RST_N       in   1   asynchronous active-low reset
//   FIFO_EMPTY  in   4   per-channel empty flag (1 = empty)
//   FIFO_DATA   in  32   channel i read data on [8i+7:8i], valid the cycle after RDREQ
//   FIFO_RDREQ  out  4   one-cycle read strobe to the granted channel
//   TX_DATA     out  8   byte offered to the transmitter
//   TX_VALID    out  1   TX_DATA valid
//   TX_READY    in   1   transmitter accepts a byte (transfer = VALID && READY)
//   GRANT       out  4   one-hot frame owner, 0 when idle
//   BUSY        out  1   high from grant until frame end
//   FRAME_DONE  out  1   one-cycle pulse after the final byte transfers
module uart_tx_sched #(
    parameter int         PAYLOAD_LEN = 2,
    parameter logic [7:0] CMD         = 8'h01
) (
    input  logic        SYS_CLK,
    input  logic        RST_N,
    input  logic [3:0]  FIFO_EMPTY,
    input  logic [31:0] FIFO_DATA,
    output logic [3:0]  FIFO_RDREQ,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY,
    output logic [3:0]  GRANT,
    output logic        BUSY,
    output logic        FRAME_DONE
);

    typedef enum logic [2:0] {IDLE, HEAD, FETCH, CAPT, PAY, TAIL} state_t;

    state_t     state;
    logic [1:0] last_ptr;    // channel that owned the previous frame
    logic [1:0] gnt_id;      // channel owning the current frame
    logic [1:0] byte_idx;    // position inside header / trailer
    logic [7:0] remaining;   // payload bytes still to send
    logic       capt_wait;   // first CAPT cycle: RDREQ is on the wire, data not yet valid

    logic       req_any;
    logic [1:0] next_id;
    logic       xfer;
    logic [7:0] hdr_byte;
    logic [7:0] tail_byte;
    logic [7:0] fifo_byte;

    // Round-robin pick: scan from last_ptr+1 upwards, last_ptr itself last.
    // Descending loop so the nearest non-empty channel is the final write.
    always_comb begin
        req_any = 1'b0;
        next_id = last_ptr;
        for (int k = 4; k >= 1; k--) begin
            if (!FIFO_EMPTY[last_ptr + 2'(k)]) begin
                req_any = 1'b1;
                next_id = last_ptr + 2'(k);
            end
        end
    end

    assign xfer      = TX_VALID && TX_READY;
    assign fifo_byte = FIFO_DATA[{gnt_id, 3'b000} +: 8];
    assign tail_byte = (byte_idx == 2'd0) ? ~CMD : CMD;

    always_comb begin
        case (byte_idx)
            2'd0:    hdr_byte = CMD;
            2'd1:    hdr_byte = ~CMD;
            default: hdr_byte = {6'b0, gnt_id};
        endcase
    end

    // Byte phases (HEAD/TAIL/PAY) drop TX_VALID on the edge after a transfer
    // and only reload on the following edge, which guarantees the idle gap
    // between bytes and keeps TX_DATA frozen while a byte is being held off.
    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            last_ptr   <= 2'd3;
            gnt_id     <= 2'd0;
            byte_idx   <= 2'd0;
            remaining  <= 8'd0;
            capt_wait  <= 1'b0;
            FIFO_RDREQ <= 4'b0;
            TX_DATA    <= 8'h00;
            TX_VALID   <= 1'b0;
            GRANT      <= 4'b0;
            BUSY       <= 1'b0;
            FRAME_DONE <= 1'b0;
        end else begin
            FRAME_DONE <= 1'b0;
            FIFO_RDREQ <= 4'b0;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        gnt_id    <= next_id;
                        GRANT     <= 4'b0001 << next_id;
                        BUSY      <= 1'b1;
                        byte_idx  <= 2'd0;
                        remaining <= 8'(PAYLOAD_LEN);
                        state     <= HEAD;
                    end
                end
                HEAD: begin
                    if (xfer) begin
                        TX_VALID <= 1'b0;
                        if (byte_idx == 2'd2) begin
                            byte_idx <= 2'd0;
                            state    <= FETCH;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end else if (!TX_VALID) begin
                        TX_DATA  <= hdr_byte;
                        TX_VALID <= 1'b1;
                    end
                end
                FETCH: begin
                    // Stall indefinitely on an empty owner; grant is kept.
                    if (!FIFO_EMPTY[gnt_id]) begin
                        FIFO_RDREQ <= GRANT;
                        capt_wait  <= 1'b1;
                        state      <= CAPT;
                    end
                end
                CAPT: begin
                    if (capt_wait) begin
                        capt_wait <= 1'b0;
                    end else begin
                        TX_DATA  <= fifo_byte;
                        TX_VALID <= 1'b1;
                        state    <= PAY;
                    end
                end
                PAY: begin
                    if (xfer) begin
                        TX_VALID  <= 1'b0;
                        remaining <= remaining - 8'd1;
                        state     <= (remaining == 8'd1) ? TAIL : FETCH;
                    end
                end
                TAIL: begin
                    if (xfer) begin
                        TX_VALID <= 1'b0;
                        if (byte_idx == 2'd1) begin
                            byte_idx   <= 2'd0;
                            GRANT      <= 4'b0;
                            BUSY       <= 1'b0;
                            FRAME_DONE <= 1'b1;
                            last_ptr   <= gnt_id;
                            state      <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end else if (!TX_VALID) begin
                        TX_DATA  <= tail_byte;
                        TX_VALID <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: instance 0 uses PAYLOAD_LEN=2, instance 1 uses
// PAYLOAD_LEN=1. FIFOs are modelled as queues; expected bytes are queued by
// the stimulus and consumed by a monitor on every transfer.
module tb_uart_tx_sched;

    typedef struct {
        logic [7:0] data;
        logic [3:0] gnt;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        tx_ready;
    logic [3:0]  fempty [2];
    logic [31:0] fdata  [2];
    logic [3:0]  rdreq  [2];
    logic [7:0]  txd    [2];
    logic        txv    [2];
    logic [3:0]  gnt    [2];
    logic        busy   [2];
    logic        fdone  [2];

    logic [7:0]  fq    [2][4][$];
    exp_t        exp_q [2][$];
    logic [3:0]  rd_lat [2];

    int checks   = 0;
    int failures = 0;
    int fd_cnt   [2];

    uart_tx_sched #(.PAYLOAD_LEN(2), .CMD(8'h01)) u_dut0 (
        .SYS_CLK(clk), .RST_N(rst_n), .FIFO_EMPTY(fempty[0]), .FIFO_DATA(fdata[0]),
        .FIFO_RDREQ(rdreq[0]), .TX_DATA(txd[0]), .TX_VALID(txv[0]), .TX_READY(tx_ready),
        .GRANT(gnt[0]), .BUSY(busy[0]), .FRAME_DONE(fdone[0])
    );

    uart_tx_sched #(.PAYLOAD_LEN(1), .CMD(8'h01)) u_dut1 (
        .SYS_CLK(clk), .RST_N(rst_n), .FIFO_EMPTY(fempty[1]), .FIFO_DATA(fdata[1]),
        .FIFO_RDREQ(rdreq[1]), .TX_DATA(txd[1]), .TX_VALID(txv[1]), .TX_READY(tx_ready),
        .GRANT(gnt[1]), .BUSY(busy[1]), .FRAME_DONE(fdone[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- FIFO model: data appears the cycle after RDREQ ----------------
    initial begin
        for (int i = 0; i < 2; i++) begin
            fempty[i] = 4'hF;
            fdata[i]  = 32'h0;
            rd_lat[i] = 4'h0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++)
                for (int c = 0; c < 4; c++) begin
                    if (rd_lat[i][c] && fq[i][c].size() > 0)
                        fdata[i][8*c +: 8] = fq[i][c].pop_front();
                    fempty[i][c] = (fq[i][c].size() == 0);
                end
        end
    end

    task automatic fpush(input int inst, input int ch, input logic [7:0] d);
        fq[inst][ch].push_back(d);
        fempty[inst][ch] = 1'b0;
    endtask

    task automatic exp_byte(input int inst, input logic [7:0] d, input logic [3:0] g);
        exp_t e;
        e.data = d;
        e.gnt  = g;
        exp_q[inst].push_back(e);
    endtask

    // Full frame; p1 is used only by the PAYLOAD_LEN=2 instance.
    task automatic exp_frame(input int inst, input int ch, input logic [7:0] p0, input logic [7:0] p1);
        logic [3:0] g;
        g = 4'b0001 << ch;
        exp_byte(inst, 8'h01, g);
        exp_byte(inst, 8'hFE, g);
        exp_byte(inst, 8'(ch), g);
        exp_byte(inst, p0, g);
        if (inst == 0) exp_byte(inst, p1, g);
        exp_byte(inst, 8'hFE, g);
        exp_byte(inst, 8'h01, g);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic       pv [2];
        logic       pr [2];
        logic [7:0] pd [2];
        int         frame_rd [2];
        exp_t       e;
        for (int i = 0; i < 2; i++) begin
            pv[i] = 0; pr[i] = 0; pd[i] = 0; frame_rd[i] = 0; fd_cnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                rd_lat[i] = rdreq[i];
                if (!rst_n) begin
                    pv[i] = 0; pr[i] = 0; frame_rd[i] = 0;
                end else begin
                    if (pv[i] && !pr[i]) begin
                        chk("hold_valid", 32'(txv[i]), 32'd1);
                        chk("hold_data", 32'(txd[i]), 32'(pd[i]));
                    end
                    if (pv[i] && pr[i]) chk("gap_after_xfer", 32'(txv[i]), 32'd0);
                    if (txv[i] && tx_ready) begin
                        if (exp_q[i].size() == 0) begin
                            chk("unexpected_byte", 32'(txd[i]), 32'h1FF);
                        end else begin
                            e = exp_q[i].pop_front();
                            chk("tx_byte", 32'(txd[i]), 32'(e.data));
                            chk("tx_grant", 32'(gnt[i]), 32'(e.gnt));
                        end
                    end
                    if (rdreq[i] != 4'h0) begin
                        chk("rdreq_owner", 32'(rdreq[i]), 32'(gnt[i]));
                        frame_rd[i]++;
                    end
                    if (fdone[i]) begin
                        chk("rd_per_frame", 32'(frame_rd[i]), (i == 0) ? 32'd2 : 32'd1);
                        frame_rd[i] = 0;
                        fd_cnt[i]++;
                    end
                    pv[i] = txv[i]; pr[i] = tx_ready; pd[i] = txd[i];
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_fd(input int inst, input int target);
        int n = 0;
        while (fd_cnt[inst] < target && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("frame_done_count", 32'(fd_cnt[inst]), 32'(target));
    endtask

    task automatic wait_byte(input logic [7:0] d);
        int  n = 0;
        logic hit = 0;
        while (!hit && n < 300) begin
            @(negedge clk);
            n++;
            hit = txv[0] && tx_ready && (txd[0] == d);
        end
        chk("wait_byte_seen", 32'(hit), 32'd1);
    endtask

    task automatic wait_valid();
        int n = 0;
        @(negedge clk);
        while (!txv[0] && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("wait_valid_seen", 32'(txv[0]), 32'd1);
    endtask

    task automatic chk_reset_outs(input int inst);
        chk("rst_tx_valid", 32'(txv[inst]), 32'd0);
        chk("rst_tx_data", 32'(txd[inst]), 32'd0);
        chk("rst_rdreq", 32'(rdreq[inst]), 32'd0);
        chk("rst_grant", 32'(gnt[inst]), 32'd0);
        chk("rst_busy", 32'(busy[inst]), 32'd0);
        chk("rst_frame_done", 32'(fdone[inst]), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        rst_n    = 1'b0;
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outs(0);
        chk_reset_outs(1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_grant", 32'(gnt[0]), 32'd0);
        chk("idle_busy", 32'(busy[0]), 32'd0);

        // single frame from ch0
        fpush(0, 0, 8'hA5); fpush(0, 0, 8'h5A);
        exp_frame(0, 0, 8'hA5, 8'h5A);
        wait_fd(0, 1);

        // all channels pending after a reset: order 0,1,2,3,0
        pulse_reset();
        base = fd_cnt[0];
        fpush(0, 0, 8'h10); fpush(0, 0, 8'h11); fpush(0, 0, 8'h12); fpush(0, 0, 8'h13);
        fpush(0, 1, 8'h20); fpush(0, 1, 8'h21);
        fpush(0, 2, 8'h30); fpush(0, 2, 8'h31);
        fpush(0, 3, 8'h40); fpush(0, 3, 8'h41);
        exp_frame(0, 0, 8'h10, 8'h11);
        exp_frame(0, 1, 8'h20, 8'h21);
        exp_frame(0, 2, 8'h30, 8'h31);
        exp_frame(0, 3, 8'h40, 8'h41);
        exp_frame(0, 0, 8'h12, 8'h13);
        wait_fd(0, base + 5);

        // back-pressure on ch2 payload byte
        base = fd_cnt[0];
        fpush(0, 2, 8'h3C); fpush(0, 2, 8'h3D);
        exp_frame(0, 2, 8'h3C, 8'h3D);
        wait_byte(8'h02);
        @(posedge clk); #1 tx_ready = 1'b0;
        wait_valid();
        for (int k = 0; k < 10; k++) begin
            chk("stall_valid", 32'(txv[0]), 32'd1);
            chk("stall_data", 32'(txd[0]), 32'h3C);
            @(negedge clk);
        end
        @(posedge clk); #1 tx_ready = 1'b1;
        wait_fd(0, base + 1);

        // ch1 runs dry after its first payload byte
        base = fd_cnt[0];
        fpush(0, 1, 8'h71);
        exp_frame(0, 1, 8'h71, 8'h72);
        wait_byte(8'h71);
        @(posedge clk);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("dry_rdreq", 32'(rdreq[0]), 32'd0);
            chk("dry_valid", 32'(txv[0]), 32'd0);
            chk("dry_grant", 32'(gnt[0]), 32'h2);
        end
        fpush(0, 1, 8'h72);
        wait_fd(0, base + 1);

        // reset while the 4th byte is offered
        base = fd_cnt[0];
        fpush(0, 0, 8'hB1); fpush(0, 0, 8'hB2);
        exp_byte(0, 8'h01, 4'h1); exp_byte(0, 8'hFE, 4'h1); exp_byte(0, 8'h00, 4'h1);
        wait_byte(8'h00);
        @(posedge clk); #1 tx_ready = 1'b0;
        wait_valid();
        chk("pre_reset_data", 32'(txd[0]), 32'hB1);
        #1 rst_n = 1'b0;
        #1 chk_reset_outs(0);
        chk("abort_exp_empty", 32'(exp_q[0].size()), 32'd0);
        fpush(0, 0, 8'hC1);
        exp_frame(0, 0, 8'hB2, 8'hC1);
        @(negedge clk);
        rst_n    = 1'b1;
        tx_ready = 1'b1;
        @(negedge clk);
        chk("post_reset_grant", 32'(gnt[0]), 32'h1);
        chk("post_reset_busy", 32'(busy[0]), 32'd1);
        wait_fd(0, base + 1);

        // PAYLOAD_LEN=1 instance: ch3 alone twice, then ch0 beats ch3
        base = fd_cnt[1];
        fpush(1, 3, 8'h9C);
        exp_frame(1, 3, 8'h9C, 8'h00);
        wait_fd(1, base + 1);
        fpush(1, 3, 8'h9D);
        exp_frame(1, 3, 8'h9D, 8'h00);
        wait_fd(1, base + 2);
        fpush(1, 0, 8'hE0); fpush(1, 3, 8'hE3);
        exp_frame(1, 0, 8'hE0, 8'h00);
        exp_frame(1, 3, 8'hE3, 8'h00);
        wait_fd(1, base + 4);

        repeat (4) @(negedge clk);
        chk("leftover_exp0", 32'(exp_q[0].size()), 32'd0);
        chk("leftover_exp1", 32'(exp_q[1].size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
